alu_issue_ctrl: RTL and testbench

//  Upstream issue/capture stage for the 8-bit combinational ALU. Accepts one

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue/capture stage.
//   - Opcode values as seen on the ALU select port (OP_ADD .. OP_SHR);
//     anything above OP_LAST is an illegal opcode.
//   - Error codes reported on res_err.
//   - State encoding of the issue FSM.
//   - Small helper that classifies an opcode as legal or illegal.
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU select encoding
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_LAST = OP_SHR;

  // Result error codes
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // True for opcodes the ALU defines a function for.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue/capture stage in front of an 8-bit combinational ALU. One command
//   is accepted per cmd handshake, presented to the ALU from registers for one
//   cycle, and the ALU response is captured into a registered result with
//   flags that is held until the consumer takes it.
//
//   The stage never computes arithmetic itself. It only:
//     - replaces undefined selects (illegal opcodes) and divide-by-zero with
//       select 0 so the ALU is never asked for something undefined,
//     - overrides the captured result for those two error cases,
//     - masks the carry flag to ADD only.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  stage idle and able to take a command
//   cmd_a      in   operand a
//   cmd_b      in   operand b
//   cmd_op     in   opcode (ALU select encoding)
//   alu_a      out  registered operand a to the ALU
//   alu_b      out  registered operand b to the ALU
//   alu_sel    out  registered (sanitised) select to the ALU
//   alu_out    in   ALU result
//   alu_carry  in   ALU carry out of a+b
//   res_valid  out  result present
//   res_ready  in   consumer accepts result
//   res_data   out  registered result
//   res_carry  out  carry flag, ADD only
//   res_zero   out  res_data == 0
//   res_err    out  00 ok, 01 illegal op, 10 divide-by-zero
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SEL_W       = 4,
  parameter logic [DATA_W-1:0] DIV0_RESULT = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_op,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  // result side
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic [1:0]        res_err
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q,   alu_sel_d;
  // Classification of the in-flight command, decided at accept time so the
  // capture cycle only has to pick between ALU output and an override.
  logic [1:0]          err_pend_q,  err_pend_d;
  logic                is_add_q,    is_add_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q,  res_data_d;
  logic                res_carry_q, res_carry_d;
  logic                res_zero_q,  res_zero_d;
  logic [1:0]          res_err_q,   res_err_d;

  // Command classification
  logic                cmd_legal;
  logic                cmd_div0;
  logic [1:0]          cmd_err;

  // Values the result registers take at the end of the ISSUE cycle
  logic [DATA_W-1:0]   cap_data;
  logic                cap_carry;
  logic                cap_zero;

  // -------------------------------------------------------------------------
  // Command classification
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_legal = op_is_legal(4'(cmd_op)) && (cmd_op <= SEL_W'(OP_LAST));
    cmd_div0  = (cmd_op == SEL_W'(OP_DIV)) && (cmd_b == '0);
    cmd_err   = ERR_OK;
    if (!cmd_legal) begin
      cmd_err = ERR_ILLEGAL;
    end else if (cmd_div0) begin
      cmd_err = ERR_DIV0;
    end
  end

  // -------------------------------------------------------------------------
  // Flag / capture logic: what the result registers load in ISSUE
  // -------------------------------------------------------------------------
  always_comb begin
    cap_data  = alu_out;
    cap_carry = is_add_q & alu_carry;
    case (err_pend_q)
      ERR_ILLEGAL: begin
        cap_data  = '0;
        cap_carry = 1'b0;
      end
      ERR_DIV0: begin
        cap_data  = DIV0_RESULT;
        cap_carry = 1'b0;
      end
      default: begin
        cap_data  = alu_out;
        cap_carry = is_add_q & alu_carry;
      end
    endcase
    cap_zero = (cap_data == '0);
  end

  // -------------------------------------------------------------------------
  // FSM next state and register next values
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    err_pend_d  = err_pend_q;
    is_add_d    = is_add_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d    = cmd_a;
          alu_b_d    = cmd_b;
          // Any error case parks the ALU on select 0 (a defined function),
          // so the ALU never sees an undefined select or a zero divisor.
          alu_sel_d  = (cmd_err == ERR_OK) ? cmd_op : '0;
          err_pend_d = cmd_err;
          is_add_d   = (cmd_op == SEL_W'(OP_ADD));
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // ALU has had a full cycle to settle on the registered operands.
        res_valid_d = 1'b1;
        res_data_d  = cap_data;
        res_carry_d = cap_carry;
        res_zero_d  = cap_zero;
        res_err_d   = err_pend_q;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      err_pend_q  <= ERR_OK;
      is_add_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      err_pend_q  <= err_pend_d;
      is_add_q    <= is_add_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered or decoded from registered state)
  // -------------------------------------------------------------------------
  assign cmd_ready = (state_q == ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for the ALU issue stage. Contains a behavioural ALU driving
//   alu_out/alu_carry, a transaction-level model of the expected stage
//   outputs compared on every falling edge, and directed commands with
//   hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic [1:0] res_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_W      (8),
    .SEL_W       (4),
    .DIV0_RESULT (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_err   (res_err)
  );

  // -------------------------------------------------------------------------
  // Behavioural ALU. Carry is always the carry of a+b, whatever the select,
  // so the stage's carry masking is actually exercised.
  // -------------------------------------------------------------------------
  logic [8:0]  alu_sum;
  logic [15:0] alu_prod;
  always_comb begin
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_prod  = 16'(alu_a) * 16'(alu_b);
    alu_carry = alu_sum[8];
    alu_out   = 8'h55;
    case (alu_sel)
      4'd0: alu_out = alu_sum[7:0];
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_prod[7:0];
      4'd3: alu_out = (alu_b == 8'd0) ? 8'hAA : (alu_a / alu_b);
      4'd4: alu_out = alu_a << 1;
      4'd5: alu_out = alu_a >> 1;
      default: alu_out = 8'h55;
    endcase
  end

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic [1:0] err;
  } exp_t;

  // What the result of a command must be, straight from the opcode table.
  function automatic exp_t spec_result(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    exp_t        r;
    logic [8:0]  s;
    logic [15:0] p;
    r = '0;
    s = {1'b0, a} + {1'b0, b};
    p = 16'(a) * 16'(b);
    case (op)
      4'd0: begin r.data = s[7:0]; r.carry = s[8]; end
      4'd1: r.data = a - b;
      4'd2: r.data = p[7:0];
      4'd3: begin
        if (b == 8'd0) begin
          r.data = 8'hFF;
          r.err  = 2'b10;
        end else begin
          r.data = a / b;
        end
      end
      4'd4: r.data = a << 1;
      4'd5: r.data = a >> 1;
      default: r.err = 2'b01;
    endcase
    return r;
  endfunction

  // Model: a command is in flight from acceptance until the result handshake;
  // the result appears one cycle after acceptance.
  logic       m_live = 1'b0;
  logic       m_busy;
  int         m_age;
  exp_t       m_pend;
  logic       m_res_valid;
  exp_t       m_res;
  logic       m_zero;
  logic [7:0] m_alu_a;
  logic [7:0] m_alu_b;
  logic [3:0] m_alu_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_live      <= 1'b1;
      m_busy      <= 1'b0;
      m_age       <= 0;
      m_pend      <= '0;
      m_res_valid <= 1'b0;
      m_res       <= '0;
      m_zero      <= 1'b0;
      m_alu_a     <= 8'd0;
      m_alu_b     <= 8'd0;
      m_alu_sel   <= 4'd0;
    end else if (m_live) begin
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy    <= 1'b1;
          m_age     <= 1;
          m_pend    <= spec_result(cmd_a, cmd_b, cmd_op);
          m_alu_a   <= cmd_a;
          m_alu_b   <= cmd_b;
          m_alu_sel <= (spec_result(cmd_a, cmd_b, cmd_op).err == 2'b00) ? cmd_op : 4'd0;
        end
      end else if (m_age == 1) begin
        m_age       <= 2;
        m_res_valid <= 1'b1;
        m_res       <= m_pend;
        m_zero      <= (m_pend.data == 8'd0);
      end else if (res_ready) begin
        m_busy      <= 1'b0;
        m_age       <= 0;
        m_res_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("m_res_valid", 32'(res_valid), 32'(m_res_valid));
      chk("m_alu_a",     32'(alu_a),     32'(m_alu_a));
      chk("m_alu_b",     32'(alu_b),     32'(m_alu_b));
      chk("m_alu_sel",   32'(alu_sel),   32'(m_alu_sel));
      chk("m_res_data",  32'(res_data),  32'(m_res.data));
      chk("m_res_carry", 32'(res_carry), 32'(m_res.carry));
      chk("m_res_zero",  32'(res_zero),  32'(m_zero));
      chk("m_res_err",   32'(res_err),   32'(m_res.err));
    end
  end

  // -------------------------------------------------------------------------
  // Directed transaction: drive, check latency/select/result literals, stall
  // the consumer for 'stall' cycles while a junk command is held on the
  // input, then complete the handshake.
  // -------------------------------------------------------------------------
  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [3:0] exp_sel,
                         input logic [7:0] exp_data, input logic exp_carry,
                         input logic exp_zero, input logic [1:0] exp_err,
                         input int stall);
    int n;
    int stall_ok;
    @(negedge clk);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    res_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    // accepted on the coming rising edge -> ISSUE
    @(negedge clk);
    chk({tag, "_issue_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_issue_sel"},   32'(alu_sel),   32'(exp_sel));
    chk({tag, "_issue_ready"}, 32'(cmd_ready), 32'd0);
    // producer already presents its next command; it must not be taken yet
    cmd_a  = 8'($urandom);
    cmd_b  = 8'($urandom);
    cmd_op = 4'($urandom_range(0, 5));
    @(negedge clk);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_data"},  32'(res_data),  32'(exp_data));
    chk({tag, "_carry"}, 32'(res_carry), 32'(exp_carry));
    chk({tag, "_zero"},  32'(res_zero),  32'(exp_zero));
    chk({tag, "_err"},   32'(res_err),   32'(exp_err));
    stall_ok = 1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!(res_valid && !cmd_ready && res_data == exp_data)) stall_ok = 0;
    end
    if (stall > 0) chk({tag, "_stall_hold"}, 32'(stall_ok), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
    $display("cmd %s a=%02h b=%02h op=%0d -> data=%02h carry=%0b zero=%0b err=%0d",
             tag, a, b, op, exp_data, exp_carry, exp_zero, exp_err);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    cmd_op    = 4'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_zero",  32'(res_zero),  32'd0);
    chk("rst_alu_sel",   32'(alu_sel),   32'd0);
    rst = 1'b0;

    //       tag      a      b      op     sel    data   c     z     err    stall
    run_cmd("add",   8'hF0, 8'h20, 4'd0,  4'd0,  8'h10, 1'b1, 1'b0, 2'b00, 0);
    run_cmd("sub0",  8'h05, 8'h05, 4'd1,  4'd1,  8'h00, 1'b0, 1'b1, 2'b00, 0);
    run_cmd("div0",  8'h09, 8'h00, 4'd3,  4'd0,  8'hFF, 1'b0, 1'b0, 2'b10, 0);
    run_cmd("div",   8'h09, 8'h02, 4'd3,  4'd3,  8'h04, 1'b0, 1'b0, 2'b00, 0);
    run_cmd("ill_a", 8'h03, 8'h04, 4'hA,  4'd0,  8'h00, 1'b0, 1'b1, 2'b01, 0);
    run_cmd("mul",   8'h10, 8'h10, 4'd2,  4'd2,  8'h00, 1'b0, 1'b1, 2'b00, 4);
    run_cmd("subneg",8'h03, 8'h05, 4'd1,  4'd1,  8'hFE, 1'b0, 1'b0, 2'b00, 1);
    run_cmd("shl",   8'h81, 8'h77, 4'd4,  4'd4,  8'h02, 1'b0, 1'b0, 2'b00, 0);
    run_cmd("shr",   8'h81, 8'h77, 4'd5,  4'd5,  8'h40, 1'b0, 1'b0, 2'b00, 0);
    run_cmd("addnc", 8'h7F, 8'h01, 4'd0,  4'd0,  8'h80, 1'b0, 1'b0, 2'b00, 0);
    run_cmd("ill_f", 8'hF0, 8'h20, 4'hF,  4'd0,  8'h00, 1'b0, 1'b1, 2'b01, 2);
    run_cmd("ill_6", 8'h12, 8'h34, 4'd6,  4'd0,  8'h00, 1'b0, 1'b1, 2'b01, 0);

    // Reset while a result is held
    @(negedge clk);
    cmd_a     = 8'hF0;
    cmd_b     = 8'h20;
    cmd_op    = 4'd0;
    cmd_valid = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);            // ISSUE
    cmd_valid = 1'b0;
    @(negedge clk);            // HOLD
    chk("hold_before_rst", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("hold_rst_valid", 32'(res_valid), 32'd0);
    chk("hold_rst_ready", 32'(cmd_ready), 32'd1);
    chk("hold_rst_data",  32'(res_data),  32'd0);
    chk("hold_rst_carry", 32'(res_carry), 32'd0);
    chk("hold_rst_zero",  32'(res_zero),  32'd0);
    chk("hold_rst_err",   32'(res_err),   32'd0);
    chk("hold_rst_alu",   32'({alu_a, alu_b, alu_sel}), 32'd0);
    $display("cmd rst_in_hold -> outputs cleared");
    run_cmd("add11", 8'h01, 8'h01, 4'd0,  4'd0,  8'h02, 1'b0, 1'b0, 2'b00, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
